pixel_frame_streamer: RTL and testbench
=======================================

Name: pixel_frame_streamer

Overview:
Transmit side of the cnn_top pixel interface. Holds one IX×IY 8-bit frame in an internal RAM, loaded through a simple write port. On a start command, replays the frame as a raster stream (row-major, pixel index 0 first) with a valid/ready handshake. Sits between the host/UART loader and cnn_top; o_valid/o_pixel feed cnn_top i_valid/i_pixel.

Parameters:
I_F_BW, 8, pixel width in bits
IX, 28, frame width in pixels
IY, 28, frame height in pixels
AW, $clog2(IX*IY), frame RAM address width (derived, do not override)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
i_wr_en  in  1  frame RAM write strobe
i_wr_addr  in  AW  write address, 0..IX*IY-1
i_wr_data  in  I_F_BW  write data
i_start  in  1  start-of-frame request; single-cycle pulse or level
i_ready  in  1  downstream accepts the current beat
o_valid  out  1  o_pixel is valid
o_pixel  out  I_F_BW  pixel data
o_last  out  1  high with the final pixel (index IX*IY-1)
o_row  out  $clog2(IY)  row of the current o_pixel
o_col  out  $clog2(IX)  column of the current o_pixel
o_busy  out  1  frame transfer in progress
o_done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset: o_valid, o_last, o_busy, o_done = 0; o_pixel, o_row, o_col = 0; FSM = IDLE; read pointer = 0; skid empty. RAM contents are not reset.
- Beat transfer: o_valid & i_ready at a rising edge. When o_valid is 1 and i_ready is 0, o_pixel/o_last/o_row/o_col hold stable. o_valid never drops without a transfer.
- RAM: single-port-read / single-port-write, synchronous read, 1-cycle latency. A write to an out-of-range address (≥ IX*IY) is dropped.
- Writes are accepted only in IDLE. While o_busy=1, i_wr_en is ignored.
- FSM states:
  - IDLE: on i_start, go to PRIME and issue a read of address 0. o_busy=1 from the next cycle.
  - PRIME: read data lands in the output register. o_valid=1 two cycles after the start edge (start sampled at edge T0, o_valid high after edge T2). Go to STREAM.
  - STREAM: advance the read pointer whenever the output register or skid will have space. Skid buffer holds one entry.
  - With i_ready held 1, throughput is exactly 1 beat per cycle: IX*IY consecutive o_valid cycles, no bubbles.
  - When i_ready deasserts, the one in-flight RAM read goes to the skid entry. Reads stall until the skid drains.
  - When the beat with o_last is accepted, go to DONE.
  - DONE: o_done=1 for exactly one cycle; o_busy=0, o_valid=0; return to IDLE.
- i_start during PRIME, STREAM or DONE is ignored (no restart, no queueing). i_start on the same cycle as i_wr_en in IDLE: the write completes, and the stream starts.
- o_row/o_col track o_pixel. o_col wraps IX-1→0 with o_row++. The final beat is row IY-1, col IX-1, with o_last=1.
- Reset asserted mid-frame: all state clears immediately (async). No o_done. Frame data is retained, so a new i_start replays from pixel 0.
- Back-to-back frames: i_start asserted in the o_done cycle is ignored. The earliest accepted start is the cycle after o_done.

Decomposition:
- Shared package cnn_pkg: I_F_BW, IX, IY defaults, the state typedef (IDLE, PRIME, STREAM, DONE), and an IMG_PIX = IX*IY constant, shared with cnn_top and its line buffer.
- One sub-module, frame_ram: a sync-read / sync-write array, IX*IY × I_F_BW, inferable as BRAM.
- The skid and FSM stay in the top module.

Test Plan:
- Load mem[i] = (i+1) mod 256 for i = 0..783, pulse i_start, hold i_ready=1 → o_valid rises 2 cycles after start. 784 consecutive beats with pixels 1,2,…,255,0,1,…,16. o_last only on beat 784 (row 27, col 27, pixel 16). o_done pulses the next cycle.
- Same image with i_ready toggling in a pseudo-random 50% pattern → beat sequence identical to the previous test, with no drops or duplicates. o_pixel stays stable while i_ready=0. Beat count = 784.
- Hold i_ready=0 on the last beat for 10 cycles → o_last and o_pixel=16 hold. o_done does not fire until the acceptance cycle +1.
- During STREAM, drive i_wr_en to address 5 with 0xAA and pulse i_start again → write ignored. The stream is unaffected, and a second replay still shows pixel 6 at index 5.
- Assert reset_n=0 at beat 300 for 3 cycles, then pulse i_start → outputs zero during reset, no o_done. The replay starts at pixel 1 and row/col 0,0.
- Connect to cnn_top (all weights 1, bias 0) → cnn_top o_done is asserted, and its first 5×5 window equals rows 0–4, cols 0–4 of the loaded image.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the cnn_top pixel path: default frame geometry and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cnn_pkg;

    localparam int I_F_BW  = 8;
    localparam int IX      = 28;
    localparam int IY      = 28;
    localparam int IMG_PIX = IX * IY;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM,
        DONE
    } state_t;

endpackage

// File: rtl/frame_ram.sv
// Frame store: one write port and one synchronous read port, DEPTH x DW, no reset.
// Latency: read data valid the cycle after rd_en.
// Backpressure: none; the caller only issues reads it has room to absorb.
module frame_ram
    import cnn_pkg::*;
#(
    parameter  int DW    = I_F_BW,
    parameter  int DEPTH = IMG_PIX,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:DEPTH-1];

    // Write and registered read share the clock; contents are left unreset so the array maps to block RAM
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/pixel_frame_streamer.sv
// Holds one IX x IY frame and replays it as a raster valid/ready stream on each start.
// Latency: first beat valid two cycles after start is sampled; then one beat per cycle.
// Backpressure: output register plus one-entry skid absorb the in-flight RAM read; reads stall while both are full.
module pixel_frame_streamer #(
    parameter  int I_F_BW = cnn_pkg::I_F_BW,
    parameter  int IX     = cnn_pkg::IX,
    parameter  int IY     = cnn_pkg::IY,
    localparam int AW     = $clog2(IX * IY),
    localparam int RW     = $clog2(IY),
    localparam int CW     = $clog2(IX)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [I_F_BW-1:0] i_wr_data,
    input  logic              i_start,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [I_F_BW-1:0] o_pixel,
    output logic              o_last,
    output logic [RW-1:0]     o_row,
    output logic [CW-1:0]     o_col,
    output logic              o_busy,
    output logic              o_done
);

    import cnn_pkg::*;

    localparam int              N_PIX     = IX * IY;
    localparam logic [AW:0]     N_PIX_W   = (AW + 1)'(N_PIX);
    localparam logic [AW-1:0]   LAST_ADDR = AW'(N_PIX - 1);
    localparam logic [CW-1:0]   COL_MAX   = CW'(IX - 1);

    typedef struct packed {
        logic              last;
        logic [RW-1:0]     row;
        logic [CW-1:0]     col;
        logic [I_F_BW-1:0] pix;
    } beat_t;

    state_t            state;
    logic              busy_q;
    logic              done_q;

    logic [AW-1:0]     rd_addr;
    logic [RW-1:0]     rd_row;
    logic [CW-1:0]     rd_col;
    logic              rd_all;
    logic              rd_vld;
    logic              tag_last;
    logic [RW-1:0]     tag_row;
    logic [CW-1:0]     tag_col;

    logic [I_F_BW-1:0] ram_data;
    beat_t             ram_beat;
    beat_t             out_q;
    beat_t             skid_q;
    logic              out_vld;
    logic              skid_vld;

    logic              wr_ok;
    logic              pop;
    logic              rd_en;
    logic [1:0]        occ_next;

    // Loading is only allowed between frames, and addresses past the frame are dropped
    assign wr_ok    = i_wr_en && (state == IDLE) && ({1'b0, i_wr_addr} < N_PIX_W);
    assign pop      = out_vld & i_ready;
    // Beats held or in flight after this cycle's pop; output reg + skid give room for two
    assign occ_next = 2'(out_vld) + 2'(skid_vld) + 2'(rd_vld) - 2'(pop);
    assign rd_en    = ((state == PRIME) || (state == STREAM)) && !rd_all && (occ_next < 2'd2);
    assign ram_beat = {tag_last, tag_row, tag_col, ram_data};

    frame_ram #(
        .DW    (I_F_BW),
        .DEPTH (N_PIX)
    ) u_frame_ram (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (i_wr_addr),
        .wr_data (i_wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_data)
    );

    // Frame sequencing: start accepted only in IDLE, done pulses for the single DONE cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state  <= PRIME;
                        busy_q <= 1'b1;
                    end
                end
                PRIME: begin
                    state <= STREAM;
                end
                STREAM: begin
                    if (pop && out_q.last) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Raster read pointer; the row/col/last tag travels alongside the one-cycle RAM read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr  <= '0;
            rd_row   <= '0;
            rd_col   <= '0;
            rd_all   <= 1'b0;
            rd_vld   <= 1'b0;
            tag_last <= 1'b0;
            tag_row  <= '0;
            tag_col  <= '0;
        end else begin
            rd_vld <= rd_en;
            if (state == IDLE) begin
                rd_addr <= '0;
                rd_row  <= '0;
                rd_col  <= '0;
                rd_all  <= 1'b0;
            end else if (rd_en) begin
                rd_addr  <= rd_addr + 1'b1;
                tag_last <= (rd_addr == LAST_ADDR);
                tag_row  <= rd_row;
                tag_col  <= rd_col;
                if (rd_addr == LAST_ADDR) begin
                    rd_all <= 1'b1;
                end
                if (rd_col == COL_MAX) begin
                    rd_col <= '0;
                    rd_row <= rd_row + 1'b1;
                end else begin
                    rd_col <= rd_col + 1'b1;
                end
            end
        end
    end

    // Output register refills from skid first, then from RAM; RAM data parks in skid when output stalls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q    <= '0;
            out_vld  <= 1'b0;
            skid_q   <= '0;
            skid_vld <= 1'b0;
        end else if (pop || !out_vld) begin
            if (skid_vld) begin
                out_q    <= skid_q;
                out_vld  <= 1'b1;
                skid_vld <= rd_vld;
                if (rd_vld) begin
                    skid_q <= ram_beat;
                end
            end else if (rd_vld) begin
                out_q   <= ram_beat;
                out_vld <= 1'b1;
            end else begin
                out_vld <= 1'b0;
            end
        end else if (rd_vld) begin
            skid_q   <= ram_beat;
            skid_vld <= 1'b1;
        end
    end

    assign o_valid = out_vld;
    assign o_pixel = out_q.pix;
    assign o_last  = out_q.last;
    assign o_row   = out_q.row;
    assign o_col   = out_q.col;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_pixel_frame_streamer.sv
module tb_pixel_frame_streamer;

    localparam int BW = cnn_pkg::I_F_BW;
    localparam int NX = cnn_pkg::IX;
    localparam int NY = cnn_pkg::IY;
    localparam int NP = NX * NY;
    localparam int AW = $clog2(NP);
    localparam int RW = $clog2(NY);
    localparam int CW = $clog2(NX);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          i_wr_en = 1'b0;
    logic [AW-1:0] i_wr_addr = '0;
    logic [BW-1:0] i_wr_data = '0;
    logic          i_start = 1'b0;
    logic          i_ready = 1'b0;
    logic          o_valid;
    logic [BW-1:0] o_pixel;
    logic          o_last;
    logic [RW-1:0] o_row;
    logic [CW-1:0] o_col;
    logic          o_busy;
    logic          o_done;

    int checks = 0;
    int errors = 0;

    // Reference frame contents; expected beat k is model[k] at row k/NX, col k%NX
    logic [BW-1:0] model [NP];

    typedef struct {
        logic          start;
        logic          ready;
        logic          e_valid;
        logic          e_busy;
        logic [BW-1:0] e_pix;
        int            e_row;
        int            e_col;
        logic          e_last;
    } vec_t;

    vec_t tbl [10];

    always #5 clk = ~clk;

    pixel_frame_streamer #(
        .I_F_BW (BW),
        .IX     (NX),
        .IY     (NY)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_wr_en   (i_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_start   (i_start),
        .i_ready   (i_ready),
        .o_valid   (o_valid),
        .o_pixel   (o_pixel),
        .o_last    (o_last),
        .o_row     (o_row),
        .o_col     (o_col),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_busy"},  o_busy,  0);
        check({tag, "_done"},  o_done,  0);
        check({tag, "_last"},  o_last,  0);
        check({tag, "_pixel"}, o_pixel, 0);
        check({tag, "_row"},   o_row,   0);
        check({tag, "_col"},   o_col,   0);
    endtask

    task automatic load_frame(input bit rnd);
        for (int i = 0; i < NP; i++) begin
            model[i]  = rnd ? 8'($urandom) : 8'((i + 1) % 256);
            i_wr_en   = 1'b1;
            i_wr_addr = AW'(i);
            i_wr_data = model[i];
            step();
        end
        // Addresses beyond the frame must not disturb anything
        for (int i = NP; i < (1 << AW); i += 37) begin
            i_wr_addr = AW'(i);
            i_wr_data = 8'hEE;
            step();
        end
        i_wr_en = 1'b0;
    endtask

    task automatic start_frame(input bit wr, input int waddr, input logic [BW-1:0] wdata);
        i_start   = 1'b1;
        i_wr_en   = wr;
        i_wr_addr = AW'(waddr);
        i_wr_data = wdata;
        step();
        i_start = 1'b0;
        i_wr_en = 1'b0;
        check("t0_busy", o_busy, 1);
        check("t0_valid", o_valid, 0);
        step();
        check("t1_valid", o_valid, 0);
        step();
        check("t2_valid", o_valid, 1);
    endtask

    // mode 0: ready always 1; mode 1: random 50%; mode 2: hold ready low 10 cycles on the last beat
    task automatic run_stream(input int start_k, input int mode, input int abort_at, input bit inject);
        int   k = start_k;
        int   cyc = 0;
        int   hold = 0;
        bit   fin = 0;
        bit   aborted = 0;
        bit   r;
        bit   acc;
        logic sv, sl;
        logic [BW-1:0] sp;
        logic [RW-1:0] sr;
        logic [CW-1:0] sc;
        while (!fin) begin
            if (abort_at >= 0 && k == abort_at) begin
                reset_n = 1'b0;
                #1;
                check_all_zero("rst_now");
                repeat (3) begin
                    step();
                    check_all_zero("rst_hold");
                end
                reset_n = 1'b1;
                i_ready = 1'b1;
                step();
                check_all_zero("rst_after");
                aborted = 1;
                fin = 1;
            end else begin
                case (mode)
                    0:       r = 1'b1;
                    1:       r = 1'($urandom % 2);
                    default: begin
                        if (o_valid && o_last && hold < 10) begin
                            r = 1'b0;
                            hold++;
                        end else begin
                            r = 1'b1;
                        end
                    end
                endcase
                i_ready = r;
                if (inject && cyc == 20) begin
                    i_wr_en   = 1'b1;
                    i_wr_addr = AW'(5);
                    i_wr_data = 8'hAA;
                    i_start   = 1'b1;
                end
                sv = o_valid; sp = o_pixel; sr = o_row; sc = o_col; sl = o_last;
                acc = o_valid && r;
                step();
                i_wr_en = 1'b0;
                i_start = 1'b0;
                cyc++;
                if (acc) begin
                    check("beat_pixel", sp, model[k]);
                    check("beat_row", sr, k / NX);
                    check("beat_col", sc, k % NX);
                    check("beat_last", sl, (k == NP - 1));
                    if (k == NP - 1) begin
                        check("done_pulse", o_done, 1);
                        check("done_busy", o_busy, 0);
                        check("done_valid", o_valid, 0);
                        // A start in the done cycle must be dropped
                        i_start = 1'b1;
                        step();
                        i_start = 1'b0;
                        check("after_done", o_done, 0);
                        check("after_done_busy", o_busy, 0);
                        step();
                        check("no_queued_start", o_busy, 0);
                        check("no_queued_valid", o_valid, 0);
                        fin = 1;
                    end else begin
                        check("early_done", o_done, 0);
                        if (mode == 0) check("no_bubble", o_valid, 1);
                    end
                    k++;
                end else begin
                    check("idle_done", o_done, 0);
                    if (sv) begin
                        check("hold_valid", o_valid, 1);
                        check("hold_pixel", o_pixel, sp);
                        check("hold_row", o_row, sr);
                        check("hold_col", o_col, sc);
                        check("hold_last", o_last, sl);
                    end
                end
                if (cyc > 6000) begin
                    checks++;
                    errors++;
                    $display("FAIL stream_timeout: beats %0d required %0d", k, NP);
                    fin = 1;
                    aborted = 1;
                end
            end
        end
        if (!aborted) check("beat_count", k, NP);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //                start ready valid busy pix row col last
        tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 0, 0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 0, 0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 0, 0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 0, 0, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 0, 0, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd2, 0, 1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd3, 0, 2, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd3, 0, 2, 1'b0};
        tbl[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd3, 0, 2, 1'b0};
        tbl[9] = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd4, 0, 3, 1'b0};

        repeat (3) step();
        check_all_zero("reset");
        reset_n = 1'b1;
        step();
        check_all_zero("post_reset");

        load_frame(1'b0);

        // Start latency and skid behaviour, cycle by cycle
        for (int i = 0; i < 10; i++) begin
            i_start = tbl[i].start;
            i_ready = tbl[i].ready;
            step();
            i_start = 1'b0;
            check($sformatf("vec%0d_valid", i), o_valid, tbl[i].e_valid);
            check($sformatf("vec%0d_busy", i), o_busy, tbl[i].e_busy);
            if (tbl[i].e_valid) begin
                check($sformatf("vec%0d_pixel", i), o_pixel, tbl[i].e_pix);
                check($sformatf("vec%0d_row", i), o_row, tbl[i].e_row);
                check($sformatf("vec%0d_col", i), o_col, tbl[i].e_col);
                check($sformatf("vec%0d_last", i), o_last, tbl[i].e_last);
            end
        end
        run_stream(3, 1, -1, 1'b0);

        start_frame(1'b0, 0, 8'd0);
        run_stream(0, 0, -1, 1'b0);

        start_frame(1'b0, 0, 8'd0);
        run_stream(0, 1, -1, 1'b0);

        start_frame(1'b0, 0, 8'd0);
        run_stream(0, 2, -1, 1'b0);

        start_frame(1'b0, 0, 8'd0);
        run_stream(0, 1, -1, 1'b1);

        start_frame(1'b0, 0, 8'd0);
        run_stream(0, 0, -1, 1'b0);

        start_frame(1'b0, 0, 8'd0);
        run_stream(0, 1, 300, 1'b0);
        start_frame(1'b0, 0, 8'd0);
        run_stream(0, 0, -1, 1'b0);

        load_frame(1'b1);
        model[0] = 8'h5A;
        start_frame(1'b1, 0, 8'h5A);
        run_stream(0, 1, -1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
